gf180mcu_osu_sc_gp9t3v3__ro_cnt: RTL and testbench
==================================================

# gf180mcu_osu_sc_gp9t3v3__ro_cnt

Ring-oscillator frequency meter for the gp9t3v3 characterization macro. It consumes the free-running output of a ring of `inv_8` cells and counts the oscillator's rising edges over a programmable window of system-clock cycles. The result measures inverter delay on silicon. It sits directly downstream of the inverter chain, and its count result is read by the test controller.

## Interface
Parameters:
- `CNT_W`, default 16: width of the edge counter and `COUNT`.
- `WIN_W`, default 16: width of `WINDOW`.

Ports:
- `CLK`, input, 1: system clock, rising-edge.
- `RST`, input, 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `START`, input, 1: request a measurement; sampled only in IDLE or DONE.
- `WINDOW`, input, `WIN_W`: gate length in `CLK` cycles; sampled with `START`.
- `RO_IN`, input, 1: ring-oscillator output, asynchronous to `CLK`.
- `BUSY`, output, 1: measurement in progress.
- `DONE`, output, 1: one-cycle pulse when `COUNT` becomes valid.
- `COUNT`, output, `CNT_W`: rising edges seen in the last window; held until the next accepted `START`.
- `OVF`, output, 1: count exceeded `2^CNT_W-1` (see Configuration).

## Operation
- `RO_IN` passes through a 2-flop synchronizer (s1, s2) and then an edge register s3.
- An edge is detected when s2=1 and s3=0.
- Valid measurement requires RO frequency < `CLK`/2. Faster inputs alias; this is not detected.
- FSM states:
  - IDLE: waits for `START`.
  - SYNC: exactly 2 cycles. Flushes stale synchronizer history; edges are ignored.
  - COUNT: lasts `WINDOW` cycles.
  - DONE: 1 cycle, then returns to IDLE.
- Transitions:
  - IDLE or DONE with `START`=1 goes to SYNC. Entering SYNC latches `WINDOW`, clears `COUNT` and `OVF`, and loads the window counter.
  - SYNC goes to COUNT after 2 cycles. If the latched window is 0, SYNC goes straight to DONE.
  - COUNT goes to DONE when the window counter reaches 0.
- `START` while in SYNC or COUNT is ignored. There is no queuing and no restart.
- Within COUNT, `COUNT` increments by 1 on every detected edge.
- `COUNT` is unsigned; width rules follow the overflow macro.
- A `START` in the DONE cycle is accepted. `DONE` still pulses that cycle.
- Reset (any state):
  - FSM goes to IDLE.
  - s1, s2, s3, `COUNT`, `OVF`, `BUSY` and `DONE` all go to 0.
  - Reset mid-COUNT discards the measurement; no `DONE` pulse.

## Timing
- Let `START` be sampled high at rising edge k, with W = `WINDOW`.
- SYNC covers cycles k+1 and k+2. `BUSY`=1 from k+1 through k+2+W.
- COUNT covers cycles k+3 through k+2+W. Edges whose detection falls in those cycles are counted.
- `DONE`=1 during cycle k+3+W only; `BUSY`=0 in that cycle. `COUNT` is final and stable in that cycle.
- Latency from a `RO_IN` rise to detection is 2–3 `CLK` cycles (synchronizer).
- Measurement latency from `START` to `DONE` is W+3 cycles.
- Reset values: `BUSY`=0, `DONE`=0, `COUNT`=0, `OVF`=0.

## Configuration
Macro `GF180_RO_CNT_SAT_EN`:
- Defined:
  - `COUNT` saturates at `2^CNT_W-1`.
  - An edge arriving at max sets `OVF`=1; `OVF` is sticky until the next accepted `START` or `RST`.
- Undefined:
  - `COUNT` wraps modulo `2^CNT_W`.
  - `OVF` is tied to 0.

## Test plan
- Nominal count: `RO_IN` period 4 `CLK` (50% duty), `WINDOW`=100, `START` at k. Required: `DONE` at k+103, `COUNT`=25 ±1, `OVF`=0.
- Zero window: `WINDOW`=0, `START` at k. Required: `BUSY` only at k+1 and k+2, `DONE` at k+3, `COUNT`=0.
- Overflow: `CNT_W`=4, `RO_IN` period 2, `WINDOW`=40 (about 20 edges). Required: with the macro, `COUNT`=15 and `OVF`=1; without it, `COUNT`=(edges mod 16) and `OVF`=0.
- `START` ignored while busy: pulse `START` again during COUNT. Required: single `DONE` at the original k+3+W; `COUNT` unaffected.
- Back-to-back runs: hold `START` high through the DONE cycle. Required: `DONE` pulse, new SYNC next cycle, `COUNT` cleared to 0.
- Reset mid-run: assert `RST` for 1 cycle during COUNT. Required: all outputs 0 next cycle, no `DONE`; a fresh `START` then measures correctly.

Source files
------------

// File: rtl/gf180mcu_osu_sc_gp9t3v3__ro_cnt.sv
// Ring-oscillator frequency meter: counts synchronized RO_IN rising edges over a WINDOW-cycle gate.
// Optional macro GF180_RO_CNT_SAT_EN: saturate COUNT at max and raise sticky OVF (default: wrap, OVF=0).
module gf180mcu_osu_sc_gp9t3v3__ro_cnt #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIN_W-1:0] WINDOW,
    input  logic             RO_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             phase_q, phase_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic             ovf_q, ovf_d;
    logic             edge_det;
    logic [CNT_W:0]   inc;

    // Returns {overflow, next count}; overflow only matters when saturating.
    function automatic logic [CNT_W:0] cnt_inc(input logic [CNT_W-1:0] c);
`ifdef GF180_RO_CNT_SAT_EN
        if (c == {CNT_W{1'b1}}) begin
            return {1'b1, c};
        end
        return {1'b0, c + CNT_W'(1)};
`else
        return {1'b0, c + CNT_W'(1)};
`endif
    endfunction

    assign edge_det = s2_q & ~s3_q;
    assign inc      = cnt_inc(cnt_q);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        s1_d    = RO_IN;
        s2_d    = s1_q;
        s3_d    = s2_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_d = S_SYNC;
                    phase_d = 1'b0;
                    win_d   = WINDOW;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SYNC: begin
                // Two cycles let the synchronizer shed pre-start history.
                phase_d = ~phase_q;
                if (phase_q) begin
                    state_d = (win_q == '0) ? S_DONE : S_COUNT;
                end
            end
            S_COUNT: begin
                win_d = win_q - WIN_W'(1);
                if (edge_det) begin
                    cnt_d = inc[CNT_W-1:0];
                    if (inc[CNT_W]) begin
                        ovf_d = 1'b1;
                    end
                end
                if (win_q == WIN_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            win_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
        end
    end

    assign BUSY  = (state_q == S_SYNC) || (state_q == S_COUNT);
    assign DONE  = (state_q == S_DONE);
    assign COUNT = cnt_q;
`ifdef GF180_RO_CNT_SAT_EN
    assign OVF = ovf_q;
`else
    assign OVF = 1'b0;
`endif

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__ro_cnt.sv
// Scoreboard bench for the ring-oscillator counter: RO_IN changes mid-cycle so edge timing is deterministic.
module tb_gf180mcu_osu_sc_gp9t3v3__ro_cnt;

    localparam int CNT_W = 5;
    localparam int WIN_W = 16;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST;
    logic             START;
    logic [WIN_W-1:0] WINDOW;
    logic             RO_IN;
    logic             BUSY;
    logic             DONE;
    logic [CNT_W-1:0] COUNT;
    logic             OVF;

    gf180mcu_osu_sc_gp9t3v3__ro_cnt #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .WINDOW(WINDOW), .RO_IN(RO_IN),
        .BUSY(BUSY), .DONE(DONE), .COUNT(COUNT), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int done_cyc;
        int cnt;
        int ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   last_cnt = 0;
    logic seq [0:255];

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding measurement.
    always @(negedge CLK) begin
        if (DONE) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done at cycle %0d: actual=1 required=0", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", cyc, mon_e.done_cyc);
                chk("count", int'(COUNT), mon_e.cnt);
                chk("ovf", int'(OVF), mon_e.ovf);
            end
        end
    end

    // Reference: a rise driven at negedge s+i (1<=i<=W) is detected inside the counting window.
    function automatic exp_t model(input int s, input int w);
        exp_t e;
        int   r = 0;
        for (int i = 1; i <= w; i++) begin
            if (seq[i] && !seq[i-1]) r++;
        end
        e.done_cyc = s + w + 3;
`ifdef GF180_RO_CNT_SAT_EN
        e.cnt = (r > MAXV) ? MAXV : r;
        e.ovf = (r > MAXV) ? 1 : 0;
`else
        e.cnt = r % (MAXV + 1);
        e.ovf = 0;
`endif
        return e;
    endfunction

    task automatic gen_seq(input int n, input int mode);
        for (int i = 0; i <= n; i++) begin
            if (mode == 0) seq[i] = 1'($urandom_range(0, 1));
            else           seq[i] = ((i % mode) < (mode / 2)) ? 1'b1 : 1'b0;
        end
    endtask

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic run(input int w, input int mode, input int mid, input bit hold_end);
        exp_t e;
        gen_seq(w + 2, mode);
        e = model(cyc, w);
        sb.push_back(e);
        last_cnt = e.cnt;
        START  = 1'b1;
        WINDOW = WIN_W'(w);
        RO_IN  = seq[0];
        for (int i = 1; i <= w + 2; i++) begin
            @(negedge CLK);
            chk("busy_active", int'(BUSY), 1);
            if (i == 1) begin
                chk("count_cleared", int'(COUNT), 0);
                chk("ovf_cleared", int'(OVF), 0);
            end
            START  = (i == mid) || (hold_end && i == w + 2);
            WINDOW = WIN_W'($urandom);
            RO_IN  = seq[i];
        end
        @(negedge CLK);
        chk("busy_in_done", int'(BUSY), 0);
        START = 1'b0;
    endtask

    task automatic run_rst(input int w, input int at);
        gen_seq(w + 2, 0);
        START  = 1'b1;
        WINDOW = WIN_W'(w);
        RO_IN  = seq[0];
        for (int i = 1; i <= at + 1; i++) begin
            @(negedge CLK);
            START = 1'b0;
            RO_IN = seq[i];
            if (i <= at) chk("busy_before_rst", int'(BUSY), 1);
            if (i == at) RST = 1'b1;
            if (i == at + 1) begin
                RST = 1'b0;
                chk("rst_busy", int'(BUSY), 0);
                chk("rst_done", int'(DONE), 0);
                chk("rst_count", int'(COUNT), 0);
                chk("rst_ovf", int'(OVF), 0);
            end
        end
        last_cnt = 0;
    endtask

    task automatic idle(input int n);
        START = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            chk("idle_busy", int'(BUSY), 0);
            chk("count_held", int'(COUNT), last_cnt);
        end
    endtask

    initial begin
        int w;
        int mode;
        int mid;
        bit b2b;
        RST    = 1'b1;
        START  = 1'b0;
        WINDOW = '0;
        RO_IN  = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_busy", int'(BUSY), 0);
        chk("reset_done", int'(DONE), 0);
        chk("reset_count", int'(COUNT), 0);
        chk("reset_ovf", int'(OVF), 0);
        RST = 1'b0;
        idle(2);

        run(100, 4, 0, 1'b0);           // nominal: period 4 over 100 cycles
        idle(3);
        run(0, 0, 0, 1'b0);             // zero window
        idle(3);
        run(70, 2, 0, 1'b0);            // overflow: ~35 edges into a 5-bit counter
        idle(3);
        run(30, 0, 12, 1'b0);           // START pulsed during COUNT is ignored
        idle(3);
        run(20, 3, 0, 1'b1);            // back-to-back: START held through DONE
        run(15, 0, 0, 1'b0);
        idle(3);
        run_rst(40, 20);                // reset mid-COUNT
        RO_IN = 1'b0;
        idle(50);
        run(25, 3, 0, 1'b0);            // fresh run after reset
        idle(3);

        for (int n = 0; n < 10; n++) begin
            w    = $urandom_range(0, 60);
            mode = $urandom_range(0, 4);
            mid  = (w >= 1) ? $urandom_range(3, w + 2) : 0;
            b2b  = 1'($urandom_range(0, 1));
            run(w, mode, mid, b2b);
            if (!b2b) idle($urandom_range(1, 5));
        end
        idle(3);

        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge CLK);
        chk("scoreboard_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
